// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and helpers for the registered one-hot decoder
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   // Widest select supported by the onehot helper; callers truncate to their own width.
   localparam int MAX_N = 10;

   function automatic int pow2(input int n);
      return 1 << n;
   endfunction

   function automatic logic [(1 << MAX_N)-1:0] onehot(input logic [MAX_N-1:0] s);
      logic [(1 << MAX_N)-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/decoder_n.sv
// rtl/decoder_n.sv - combinational N-to-2^N one-hot decode with enable
module decoder_n
   import decoder_pkg::*;
#(
   parameter int N = 6
) (
   input  logic                 en,
   input  logic [N-1:0]         sel,
   output logic [pow2(N)-1:0]   y
);

   localparam int W = pow2(N);

   always_comb begin
      y = '0;
      if (en) begin
         y = W'(onehot(MAX_N'(sel)));
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with direct and dwell-timed scan modes
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int N       = 6,
   parameter int DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 sel_valid,
   output logic                 sel_ready,
   input  logic [N-1:0]         sel,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [pow2(N)-1:0]   y,
   output logic [N-1:0]         idx,
   output logic                 wrap,
   output logic                 busy
);

   localparam int W = pow2(N);

   state_e               state;
   state_e               state_n;
   logic [N-1:0]         idx_n;
   logic [DWELL_W-1:0]   cnt;
   logic [DWELL_W-1:0]   cnt_n;
   logic                 wrap_n;
   logic [W-1:0]         y_n;
   logic                 transfer;

   assign sel_ready = en & ~mode;
   assign transfer  = sel_valid & sel_ready;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      wrap_n  = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else if (transfer) begin
         state_n = DIRECT;
         idx_n   = sel;
         cnt_n   = '0;
      end else if (mode) begin
         if (state != SCAN) begin
            state_n = SCAN;
            idx_n   = '0;
            cnt_n   = dwell;
         end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
         end else begin
            // Dwell is re-sampled only here, so mid-position changes wait for the reload.
            idx_n  = idx + 1'b1;
            cnt_n  = dwell;
            wrap_n = (idx == '1);
         end
      end else if (state == SCAN) begin
         // Leaving scan freezes the current position as a direct select.
         state_n = DIRECT;
         cnt_n   = '0;
      end
   end

   decoder_n #(.N(N)) u_dec (
      .en  (state_n != IDLE),
      .sel (idx_n),
      .y   (y_n)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         y     <= '0;
         idx   <= '0;
         cnt   <= '0;
         wrap  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         y     <= y_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         wrap  <= wrap_n;
         busy  <= (state_n == SCAN);
      end
   end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised registered N-to-2^N one-hot decoder with two modes.
- Direct mode: decodes a select value accepted over a valid/ready handshake.
- Scan mode: autonomously walks the one-hot output through all 2^N positions, dwelling a programmable number of cycles on each. Used for row/column strobing and chip-select sequencing.
- Sits behind control logic that previously drove a fixed 6-to-64 combinational decoder; replaces it where registered, glitch-free, sequenced selects are needed.

Parameters:
- N, 6, select width; output width is 2^N (N >= 1).
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  block enable; 0 forces outputs inactive.
- mode  input  1  0 = direct, 1 = scan.
- sel_valid  input  1  select-value valid (direct mode).
- sel_ready  output  1  combinational; equals en & ~mode.
- sel  input  N  select value to decode.
- dwell  input  DWELL_W  in scan mode, cycles per position minus 1.
- y  output  2^N  registered one-hot (or all-zero) output.
- idx  output  N  registered binary index of the active y bit.
- wrap  output  1  one-cycle pulse when scan returns to index 0.
- busy  output  1  high while state is SCAN.

Behaviour:
- Reset (dominates everything): state IDLE, y = 0, idx = 0, wrap = 0, dwell counter cnt = 0, busy = 0.
- States: IDLE, DIRECT, SCAN. y is always either all-zero or exactly one-hot; y = 0 only in IDLE.
- en = 0 in any state: next cycle state IDLE, y = 0, wrap = 0, cnt = 0, idx held.
- sel_ready = en & ~mode at all times, including in IDLE.
- Transfer = sel_valid & sel_ready.
  - On transfer, next cycle: y = 1 << sel, idx = sel, state DIRECT. Latency 1 cycle.
  - Back-to-back transfers update y every cycle.
- DIRECT with no transfer: y and idx hold.
- IDLE with en = 1 and mode = 0, no transfer: stay IDLE (y = 0) until the first transfer.
- Entering scan: en = 1 and mode = 1 while in IDLE or DIRECT. Next cycle: state SCAN, idx = 0, y = 1, cnt = dwell (sampled), wrap = 0.
- SCAN, each cycle:
  - if cnt != 0, then cnt decrements.
  - else idx = idx + 1 mod 2^N, y follows idx, cnt = dwell (re-sampled).
  - Each position is therefore held for dwell + 1 cycles; dwell = 0 advances every cycle.
- wrap = 1 for exactly the first cycle that idx is 0 after stepping from 2^N - 1. The initial entry at idx 0 does not pulse wrap.
- SCAN with mode falling to 0 (en = 1):
  - next cycle state DIRECT; y and idx hold the current scan position; cnt cleared.
  - a transfer in that same cycle takes effect instead (y = 1 << sel).
- sel_valid while mode = 1: ignored (sel_ready = 0); no state change.
- busy = (state == SCAN), registered.
- Dwell changes mid-position take effect only at the next reload.

Decomposition:
- Shared package decoder_pkg:
  - state enum {IDLE, DIRECT, SCAN};
  - constant function for 2^N;
  - function onehot(N-bit) returning 2^N bits.
- One sub-module decoder_n: purely combinational, parametrised N-to-2^N one-hot decode with enable. Instantiated once, fed by the next-idx mux; its output is registered into y in decoder_scan.

Test Plan:
- Reset then en = 1, mode = 0, sel_valid = 1, sel = 37 for 1 cycle: y = 0 during the accept cycle, next cycle y = 2^37 and idx = 37; y holds after sel_valid drops.
- Back-to-back transfers sel = 0, 63, 5 on consecutive cycles: y = bit0, bit63, bit5 on the following three cycles; sel_ready = 1 throughout.
- mode = 1, dwell = 2: y = bit0 for 3 cycles, then bit1 for 3 cycles, and so on. After 64 × 3 cycles idx returns to 0 with wrap high for exactly 1 cycle; busy = 1 throughout.
- Scan with dwell = 0, N = 2 build: idx sequence 0, 1, 2, 3, 0 on consecutive cycles; wrap asserts only with the second 0.
- During scan at idx = 10, drop mode to 0 with sel_valid = 1, sel = 3: sel_ready rises the same cycle; next cycle y = bit3, busy = 0. Repeat with sel_valid = 0: y holds bit10.
- Mid-scan en = 0: next cycle y = 0, wrap = 0, busy = 0. Mid-scan reset = 1 with en = 1: all outputs return to reset values next cycle. sel_valid while mode = 1 never changes y.
